// File: rtl/mm_pkg.sv
// Shared types for the order gateway: sides, FSM states, latched order.
// Widths here are the defaults the gateway parameters are tied to.
package mm_pkg;

  localparam int POS_W = 16;
  localparam int GW_PRICE_W = 8;
  localparam int GW_QTY_W = 8;
  localparam int GW_ID_W = 4;

  typedef enum logic {
    SIDE_BUY  = 1'b0,
    SIDE_SELL = 1'b1
  } side_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_FILL,
    ST_COOLDOWN
  } gw_state_e;

  typedef struct packed {
    side_e                 side;
    logic [GW_PRICE_W-1:0] price;
    logic [GW_QTY_W-1:0]   qty;
    logic [GW_ID_W-1:0]    id;
  } order_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/order_gateway_if.sv
// Order channel (valid/ready) toward the exchange adapter plus
// the fill report channel coming back from it.
interface order_gateway_if #(
  parameter int PRICE_W = 8,
  parameter int QTY_W = 8,
  parameter int ID_W = 4
);

  logic               ord_valid;
  logic               ord_ready;
  logic               ord_side;
  logic [PRICE_W-1:0] ord_price;
  logic [QTY_W-1:0]   ord_qty;
  logic [ID_W-1:0]    ord_id;
  logic               fill_valid;
  logic [ID_W-1:0]    fill_id;
  logic [QTY_W-1:0]   fill_qty;

  modport master (
    output ord_valid, ord_side, ord_price, ord_qty, ord_id,
    input  ord_ready, fill_valid, fill_id, fill_qty
  );

  modport slave (
    input  ord_valid, ord_side, ord_price, ord_qty, ord_id,
    output ord_ready, fill_valid, fill_id, fill_qty
  );

endinterface

// File: rtl/order_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Shared between the fill timeout and the cooldown interval.
module order_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // load wins; otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (count != '0)
      count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/order_gateway.sv
// Order gateway: one outstanding order, fill/timeout tracking, position gating.
// Optional ORDER_GATEWAY_STATS_EN adds saturating sent/filled/timeout counters.
module order_gateway
  import mm_pkg::*;
#(
  parameter int PRICE_W = GW_PRICE_W,
  parameter int QTY_W = GW_QTY_W,
  parameter int ID_W = GW_ID_W,
  parameter int ORDER_QTY = 1,
  parameter int POS_LIMIT = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int COOLDOWN_CYC = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    buy_order,
  input  logic                    sell_order,
  input  logic [PRICE_W-1:0]      bid_price,
  input  logic [PRICE_W-1:0]      ask_price,
  order_gateway_if.master         ord,
  output logic signed [POS_W-1:0] position,
  output logic                    busy,
  output logic                    timeout_err
`ifdef ORDER_GATEWAY_STATS_EN
  ,
  output logic [15:0]             stat_sent,
  output logic [15:0]             stat_filled,
  output logic [15:0]             stat_timeout
`endif
);

  localparam int TW = $clog2(
    (TIMEOUT_CYC > COOLDOWN_CYC) ? TIMEOUT_CYC : COOLDOWN_CYC);
  localparam logic [TW-1:0] TMO_LD = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] CD_LD = TW'(COOLDOWN_CYC - 1);
  localparam logic [QTY_W-1:0] OQ = QTY_W'(ORDER_QTY);
  localparam logic signed [POS_W+1:0] QTY_S = (POS_W+2)'(ORDER_QTY);
  localparam logic signed [POS_W+1:0] LIM_S = (POS_W+2)'(POS_LIMIT);

  gw_state_e state, state_nx;
  order_t    cur;
  logic [ID_W-1:0] next_id;

  logic signed [POS_W+1:0] pos_ext;
  logic buy_ok, sell_ok, req_buy, req_sell, accept;
  logic hs, fill_hit, tmo;
  logic tmr_load, tmr_done;
  logic [TW-1:0] tmr_val;
  logic [QTY_W-1:0] fq;
  logic [POS_W-1:0] fq_ext;

  assign pos_ext = {{2{position[POS_W-1]}}, position};
  assign buy_ok = (pos_ext + QTY_S) <= LIM_S;
  assign sell_ok = (pos_ext - QTY_S) >= -LIM_S;
  assign req_buy = buy_order && !sell_order && buy_ok;
  assign req_sell = sell_order && !buy_order && sell_ok;
  assign accept = (state == ST_IDLE) && (req_buy || req_sell);

  assign hs = (state == ST_SEND) && ord.ord_ready;
  assign fill_hit = (state == ST_WAIT_FILL) && ord.fill_valid
                    && (ord.fill_id == cur.id);
  assign tmo = (state == ST_WAIT_FILL) && tmr_done && !fill_hit;

  assign fq = (ord.fill_qty < OQ) ? ord.fill_qty : OQ;
  assign fq_ext = POS_W'(fq);

  assign tmr_load = hs || fill_hit || tmo;
  assign tmr_val = hs ? TMO_LD : CD_LD;

  order_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // next-state decode
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:      if (accept) state_nx = ST_SEND;
      ST_SEND:      if (hs) state_nx = ST_WAIT_FILL;
      ST_WAIT_FILL: if (fill_hit || tmo) state_nx = ST_COOLDOWN;
      ST_COOLDOWN:  if (tmr_done) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    ord.ord_valid = 1'b0;
    busy = 1'b1;
    unique case (state)
      ST_IDLE: busy = 1'b0;
      ST_SEND: ord.ord_valid = 1'b1;
      default: ;
    endcase
  end

  assign ord.ord_side = cur.side;
  assign ord.ord_price = cur.price;
  assign ord.ord_qty = cur.qty;
  assign ord.ord_id = cur.id;

  // order latch, id counter, position and timeout pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cur <= '0;
      next_id <= '0;
      position <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= tmo;
      if (accept) begin
        cur.side <= req_sell ? SIDE_SELL : SIDE_BUY;
        cur.price <= req_sell ? ask_price : bid_price;
        cur.qty <= OQ;
        cur.id <= next_id;
      end
      if (hs)
        next_id <= next_id + 1'b1;
      if (fill_hit) begin
        if (cur.side == SIDE_BUY)
          position <= position + fq_ext;
        else
          position <= position - fq_ext;
      end
    end
  end

`ifdef ORDER_GATEWAY_STATS_EN
  // saturating activity counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_sent <= '0;
      stat_filled <= '0;
      stat_timeout <= '0;
    end else begin
      if (hs) stat_sent <= sat_inc16(stat_sent);
      if (fill_hit) stat_filled <= sat_inc16(stat_filled);
      if (tmo) stat_timeout <= sat_inc16(stat_timeout);
    end
  end
`endif

endmodule

// File: tb/tb_order_gateway.sv
// Scoreboarded bench for order_gateway: directed orders, fills,
// timeouts, limit gating, id wrap and reset mid-order.
module tb_order_gateway;
  import mm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic buy_order, sell_order;
  logic [7:0] bid_price, ask_price;
  logic signed [15:0] position;
  logic busy, timeout_err;

  order_gateway_if ifc ();

  order_gateway dut (
    .clk         (clk),
    .reset       (reset),
    .buy_order   (buy_order),
    .sell_order  (sell_order),
    .bid_price   (bid_price),
    .ask_price   (ask_price),
    .ord         (ifc),
    .position    (position),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  order_t exp_q[$];
  order_t mon_e;
  logic [3:0] exp_id = 4'd0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: every handshake pops one expected order
  always @(negedge clk) begin
    if (!reset && ifc.ord_valid && ifc.ord_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_order: got id %0d side %0d price 0x%0h",
                 ifc.ord_id, ifc.ord_side, ifc.ord_price);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ord_side", 32'(ifc.ord_side), 32'(mon_e.side));
        chk("ord_price", 32'(ifc.ord_price), 32'(mon_e.price));
        chk("ord_qty", 32'(ifc.ord_qty), 32'(mon_e.qty));
        chk("ord_id", 32'(ifc.ord_id), 32'(mon_e.id));
      end
    end
  end

  // issue one order, optionally stalling ready; returns after handshake
  task automatic place(input logic sell, input logic [7:0] px,
                       input int stall);
    order_t e;
    e.side = side_e'(sell);
    e.price = px;
    e.qty = 8'd1;
    e.id = exp_id;
    exp_q.push_back(e);
    ifc.ord_ready = (stall == 0);
    if (sell) begin
      sell_order = 1'b1;
      ask_price = px;
    end else begin
      buy_order = 1'b1;
      bid_price = px;
    end
    tick(1);
    buy_order = 1'b0;
    sell_order = 1'b0;
    chk("ord_valid_rise", 32'(ifc.ord_valid), 32'd1);
    for (int i = 0; i < stall; i++) begin
      chk("hold_valid", 32'(ifc.ord_valid), 32'd1);
      chk("hold_price", 32'(ifc.ord_price), 32'(px));
      chk("hold_id", 32'(ifc.ord_id), 32'(exp_id));
      bid_price = ~px;
      ask_price = ~px;
      tick(1);
    end
    ifc.ord_ready = 1'b1;
    tick(1);
    chk("ord_valid_drop", 32'(ifc.ord_valid), 32'd0);
    exp_id = exp_id + 4'd1;
  endtask

  task automatic fill(input logic [3:0] id, input logic [7:0] qty);
    ifc.fill_valid = 1'b1;
    ifc.fill_id = id;
    ifc.fill_qty = qty;
    tick(1);
    ifc.fill_valid = 1'b0;
  endtask

  task automatic cool();
    tick(3);
    chk("cool_busy", 32'(busy), 32'd1);
    tick(1);
    chk("cool_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    buy_order = 1'b0;
    sell_order = 1'b0;
    bid_price = 8'h00;
    ask_price = 8'h00;
    ifc.ord_ready = 1'b1;
    ifc.fill_valid = 1'b0;
    ifc.fill_id = 4'd0;
    ifc.fill_qty = 8'd0;
    tick(2);
    chk("rst_valid", 32'(ifc.ord_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pos", 32'(position), 32'd0);
    chk("rst_tmo", 32'(timeout_err), 32'd0);
    chk("rst_id", 32'(ifc.ord_id), 32'd0);
    reset = 1'b0;
    tick(1);

    // basic buy, filled
    place(1'b0, 8'h70, 0);
    fill(4'd0, 8'd1);
    chk("pos_after_buy", 32'(position), 32'd1);
    cool();

    // stalled handshake, wrong-id fill, oversize fill clipped to 1
    place(1'b0, 8'h55, 5);
    fill(4'd9, 8'd1);
    chk("wrong_id_busy", 32'(busy), 32'd1);
    chk("wrong_id_pos", 32'(position), 32'd1);
    fill(4'd1, 8'd3);
    chk("pos_clip", 32'(position), 32'd2);
    cool();

    // sell that times out
    place(1'b1, 8'h91, 0);
    tick(63);
    chk("pre_tmo", 32'(timeout_err), 32'd0);
    chk("pre_tmo_busy", 32'(busy), 32'd1);
    tick(1);
    chk("tmo_pulse", 32'(timeout_err), 32'd1);
    chk("tmo_pos", 32'(position), 32'd2);
    tick(1);
    chk("tmo_once", 32'(timeout_err), 32'd0);
    tick(2);
    chk("tmo_cool_busy", 32'(busy), 32'd1);
    tick(1);
    chk("tmo_idle", 32'(busy), 32'd0);

    // fill arriving on the timeout cycle wins
    place(1'b0, 8'h33, 0);
    tick(63);
    fill(4'd3, 8'd1);
    chk("race_no_tmo", 32'(timeout_err), 32'd0);
    chk("race_pos", 32'(position), 32'd3);
    tick(1);
    chk("race_no_tmo2", 32'(timeout_err), 32'd0);
    tick(2);
    chk("race_busy", 32'(busy), 32'd1);
    tick(1);
    chk("race_idle", 32'(busy), 32'd0);

    // buy and sell together are ignored
    buy_order = 1'b1;
    sell_order = 1'b1;
    tick(2);
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_valid", 32'(ifc.ord_valid), 32'd0);
    buy_order = 1'b0;
    sell_order = 1'b0;
    tick(1);

    // 13 buys: position 3 -> 16, ids 4..15 then wrap to 0
    for (int i = 0; i < 13; i++) begin
      place(1'b0, 8'(8'h10 + i), 0);
      fill(exp_id - 4'd1, 8'd1);
      cool();
    end
    chk("pos_at_limit", 32'(position), 32'd16);

    // buy at the limit is rejected
    buy_order = 1'b1;
    bid_price = 8'h77;
    tick(2);
    chk("limit_busy", 32'(busy), 32'd0);
    chk("limit_valid", 32'(ifc.ord_valid), 32'd0);
    buy_order = 1'b0;
    tick(1);

    // sell still allowed, id 1 after the wrap
    place(1'b1, 8'h90, 0);
    fill(4'd1, 8'd1);
    chk("pos_after_sell", 32'(position), 32'd15);
    cool();

    // reset while waiting for a fill
    place(1'b0, 8'h20, 0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_id = 4'd0;
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_pos", 32'(position), 32'd0);
    chk("rw_id", 32'(ifc.ord_id), 32'd0);
    fill(4'd2, 8'd1);
    chk("rw_late_fill", 32'(position), 32'd0);
    chk("rw_late_busy", 32'(busy), 32'd0);
    place(1'b0, 8'h42, 0);
    fill(4'd0, 8'd1);
    chk("rw_new_pos", 32'(position), 32'd1);
    cool();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
